// File: rtl/con_bus_sequencer_pkg.sv
// con_bus_sequencer_pkg: shared types and helpers for the con bus sequencer.
// Revision: 1.0
`default_nettype none

`ifndef CON_SEQ_CH_OK
`define CON_SEQ_CH_OK(n) (((n) % 3) == 0)
`endif

package con_bus_sequencer_pkg;

  typedef struct packed {
    int unsigned data_width;
    int unsigned fm_width;
    int unsigned fm_height;
    int unsigned out_channels;
    int unsigned k_beats;
    int unsigned x_beats;
  } config_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_K    = 3'd1,
    S_LOAD_X    = 3'd2,
    S_TURN_OUT  = 3'd3,
    S_DRIVE_OUT = 3'd4,
    S_TURN_IN   = 3'd5
  } con_seq_state_t;

  // Counters of size 1 or 2 still need a 1-bit register.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int beat_idx_w(input int k_beats, input int x_beats);
    return clog2_min1((k_beats > x_beats) ? k_beats : x_beats);
  endfunction

endpackage

`default_nettype wire

// File: rtl/con_bus_sequencer_coord_counter.sv
// coord_counter: nested ch (step 3) / x / y output-coordinate counters.
// Revision: 1.0
`default_nettype none

module coord_counter
  import con_bus_sequencer_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int NB_CH  = 6,
  localparam int X_W   = clog2_min1(WIDTH),
  localparam int Y_W   = clog2_min1(HEIGHT),
  localparam int CH_W  = clog2_min1(NB_CH)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            clear_i,
  input  logic            advance_i,
  output logic [CH_W-1:0] ch_o,
  output logic [X_W-1:0]  x_o,
  output logic [Y_W-1:0]  y_o,
  output logic            ch_last_o,
  output logic            last_pixel_o
);

  logic [CH_W-1:0] ch_q, ch_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            w_x_last, w_y_last;

  assign ch_last_o    = (ch_q == CH_W'(NB_CH - 3));
  assign w_x_last     = (x_q == X_W'(WIDTH - 1));
  assign w_y_last     = (y_q == Y_W'(HEIGHT - 1));
  assign last_pixel_o = w_x_last && w_y_last;

  always_comb begin
    ch_d = ch_q;
    x_d  = x_q;
    y_d  = y_q;
    if (clear_i) begin
      ch_d = '0;
      x_d  = '0;
      y_d  = '0;
    end else if (advance_i) begin
      if (ch_last_o) begin
        ch_d = '0;
        if (w_x_last) begin
          x_d = '0;
          y_d = w_y_last ? '0 : y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
      end else begin
        ch_d = ch_q + CH_W'(3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ch_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      ch_q <= ch_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign ch_o = ch_q;
  assign x_o  = x_q;
  assign y_o  = y_q;

endmodule

`default_nettype wire

// File: rtl/con_bus_sequencer.sv
// con_bus_sequencer: loads K/X beats from the shared con bus, then turns it around to drive results out.
// Revision: 1.0
`default_nettype none

module con_bus_sequencer
  import con_bus_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 6,
  parameter int K_BEATS            = 18,
  parameter int X_BEATS            = 3,
  localparam int IDX_W             = beat_idx_w(K_BEATS, X_BEATS),
  localparam int X_W               = clog2_min1(FEATURE_MAP_WIDTH),
  localparam int Y_W               = clog2_min1(FEATURE_MAP_HEIGHT),
  localparam int CH_W              = clog2_min1(OUTPUT_NB_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  output logic                  running,
  input  logic                  con_valid,
  output logic                  con_ready,
  input  logic [DATA_WIDTH-1:0] con_in_1,
  input  logic [DATA_WIDTH-1:0] con_in_2,
  input  logic [DATA_WIDTH-1:0] con_in_3,
  output logic [DATA_WIDTH-1:0] con_out_1,
  output logic [DATA_WIDTH-1:0] con_out_2,
  output logic [DATA_WIDTH-1:0] con_out_3,
  output logic                  dut_driving_cons,
  output logic                  last_load_K,
  output logic                  ld_k_en,
  output logic                  ld_x_en,
  output logic [IDX_W-1:0]      ld_idx,
  output logic [DATA_WIDTH-1:0] ld_data_1,
  output logic [DATA_WIDTH-1:0] ld_data_2,
  output logic [DATA_WIDTH-1:0] ld_data_3,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data_1,
  input  logic [DATA_WIDTH-1:0] res_data_2,
  input  logic [DATA_WIDTH-1:0] res_data_3,
  output logic                  res_ready,
  output logic                  output_valid,
  output logic [X_W-1:0]        output_x,
  output logic [Y_W-1:0]        output_y,
  output logic [CH_W-1:0]       output_ch
);

  if (!`CON_SEQ_CH_OK(OUTPUT_NB_CHANNELS)) begin : g_ch_check
    $error("OUTPUT_NB_CHANNELS must be a multiple of 3");
  end

  con_seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]      k_cnt_q, k_cnt_d;
  logic [IDX_W-1:0]      x_cnt_q, x_cnt_d;
  logic                  pix_done_q, pix_done_d;
  logic                  last_pix_q, last_pix_d;
  logic                  drive_q, drive_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_1_q, out_1_d, out_2_q, out_2_d, out_3_q, out_3_d;
  logic [X_W-1:0]        out_x_q, out_x_d;
  logic [Y_W-1:0]        out_y_q, out_y_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;

  logic                  w_cnt_clear, w_cnt_adv;
  logic [CH_W-1:0]       w_ch;
  logic [X_W-1:0]        w_x;
  logic [Y_W-1:0]        w_y;
  logic                  w_ch_last, w_last_pixel;

  coord_counter #(
    .WIDTH  (FEATURE_MAP_WIDTH),
    .HEIGHT (FEATURE_MAP_HEIGHT),
    .NB_CH  (OUTPUT_NB_CHANNELS)
  ) u_coord (
    .clk          (clk),
    .arst_n       (arst_n),
    .clear_i      (w_cnt_clear),
    .advance_i    (w_cnt_adv),
    .ch_o         (w_ch),
    .x_o          (w_x),
    .y_o          (w_y),
    .ch_last_o    (w_ch_last),
    .last_pixel_o (w_last_pixel)
  );

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    x_cnt_d     = x_cnt_q;
    pix_done_d  = pix_done_q;
    last_pix_d  = last_pix_q;
    out_valid_d = 1'b0;
    out_1_d     = out_1_q;
    out_2_d     = out_2_q;
    out_3_d     = out_3_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_ch_d    = out_ch_q;
    con_ready   = 1'b0;
    res_ready   = 1'b0;
    ld_k_en     = 1'b0;
    ld_x_en     = 1'b0;
    ld_idx      = '0;
    last_load_K = 1'b0;
    w_cnt_clear = 1'b0;
    w_cnt_adv   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD_K;
          k_cnt_d     = '0;
          x_cnt_d     = '0;
          pix_done_d  = 1'b0;
          last_pix_d  = 1'b0;
          w_cnt_clear = 1'b1;
        end
      end
      S_LOAD_K: begin
        con_ready   = 1'b1;
        last_load_K = (k_cnt_q == IDX_W'(K_BEATS - 1));
        if (con_valid) begin
          ld_k_en = 1'b1;
          ld_idx  = k_cnt_q;
          if (last_load_K) begin
            k_cnt_d = '0;
            state_d = S_LOAD_X;
          end else begin
            k_cnt_d = k_cnt_q + IDX_W'(1);
          end
        end
      end
      S_LOAD_X: begin
        con_ready = 1'b1;
        if (con_valid) begin
          ld_x_en = 1'b1;
          ld_idx  = x_cnt_q;
          if (x_cnt_q == IDX_W'(X_BEATS - 1)) begin
            x_cnt_d = '0;
            state_d = S_TURN_OUT;
          end else begin
            x_cnt_d = x_cnt_q + IDX_W'(1);
          end
        end
      end
      S_TURN_OUT: begin
        pix_done_d = 1'b0;
        state_d    = S_DRIVE_OUT;
      end
      S_DRIVE_OUT: begin
        // The pixel's final beat is on the bus this cycle; take no more results.
        if (pix_done_q) begin
          state_d = last_pix_q ? S_IDLE : S_TURN_IN;
        end else begin
          res_ready = 1'b1;
          if (res_valid) begin
            out_valid_d = 1'b1;
            out_1_d     = res_data_1;
            out_2_d     = res_data_2;
            out_3_d     = res_data_3;
            out_x_d     = w_x;
            out_y_d     = w_y;
            out_ch_d    = w_ch;
            w_cnt_adv   = 1'b1;
            if (w_ch_last) begin
              pix_done_d = 1'b1;
              last_pix_d = w_last_pixel;
            end
          end
        end
      end
      S_TURN_IN: begin
        x_cnt_d = '0;
        state_d = S_LOAD_X;
      end
      default: state_d = S_IDLE;
    endcase

    drive_d = (state_d == S_TURN_OUT) || (state_d == S_DRIVE_OUT);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      k_cnt_q     <= '0;
      x_cnt_q     <= '0;
      pix_done_q  <= 1'b0;
      last_pix_q  <= 1'b0;
      drive_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_1_q     <= '0;
      out_2_q     <= '0;
      out_3_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      x_cnt_q     <= x_cnt_d;
      pix_done_q  <= pix_done_d;
      last_pix_q  <= last_pix_d;
      drive_q     <= drive_d;
      out_valid_q <= out_valid_d;
      out_1_q     <= out_1_d;
      out_2_q     <= out_2_d;
      out_3_q     <= out_3_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign running          = (state_q != S_IDLE);
  assign dut_driving_cons = drive_q;
  assign output_valid     = out_valid_q;
  assign output_x         = out_x_q;
  assign output_y         = out_y_q;
  assign output_ch        = out_ch_q;
  assign con_out_1        = out_1_q;
  assign con_out_2        = out_2_q;
  assign con_out_3        = out_3_q;
  assign ld_data_1        = (ld_k_en || ld_x_en) ? con_in_1 : '0;
  assign ld_data_2        = (ld_k_en || ld_x_en) ? con_in_2 : '0;
  assign ld_data_3        = (ld_k_en || ld_x_en) ? con_in_3 : '0;

endmodule

`default_nettype wire

// File: doc/con_bus_sequencer.md
# con_bus_sequencer

Top-level controller for the accelerator's shared three-word bidirectional bus (con_1..con_3). After `start`, it accepts kernel (K) beats, then per output pixel accepts feature (X) beats. It then turns the bus around, drives the datapath results out with their (x, y, ch) coordinates, and turns the bus back. It sits between the testbench-facing interface and the MAC datapath, owning `con_ready`, `dut_driving_cons`, `last_load_K`, `output_valid/x/y/ch` and `running`.

## Interface
- DATA_WIDTH, 16, width of each con word
- FEATURE_MAP_WIDTH, 128, output pixels per row
- FEATURE_MAP_HEIGHT, 128, output rows
- OUTPUT_NB_CHANNELS, 6, output channels; must be a multiple of 3 (elaboration assertion)
- K_BEATS, 18, three-word beats forming the full kernel set
- X_BEATS, 3, three-word beats of input features per output pixel
- clk  in  1  clock, all logic on rising edge
- arst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request to begin a layer; ignored while running
- running  out  1  high from the cycle after accepted start until the final output beat completes
- con_valid  in  1  testbench word-triple valid
- con_ready  out  1  sequencer accepts the triple on con_valid && con_ready
- con_in_1..3  in  DATA_WIDTH each  con words as seen on the bus
- con_out_1..3  out  DATA_WIDTH each  registered result words, placed on the bus when dut_driving_cons=1
- dut_driving_cons  out  1  bus direction: 1 = DUT drives
- last_load_K  out  1  high while the final K beat is offered (LOAD_K, k_cnt = K_BEATS-1)
- ld_k_en, ld_x_en  out  1 each  one-cycle strobe per accepted K / X beat
- ld_idx  out  $clog2(max(K_BEATS,X_BEATS))  index of the accepted beat
- ld_data_1..3  out  DATA_WIDTH each  con_in words forwarded with the strobe (combinational pass-through)
- res_valid  in  1  datapath result triple valid
- res_data_1..3  in  DATA_WIDTH each  result words
- res_ready  out  1  sequencer takes the result on res_valid && res_ready
- output_valid  out  1  result triple valid on the bus this cycle
- output_x / output_y / output_ch  out  $clog2 of WIDTH / HEIGHT / OUTPUT_NB_CHANNELS  coordinates; output_ch is the first of three consecutive channels

## Operation
- States: IDLE, LOAD_K, LOAD_X, TURN_OUT, DRIVE_OUT, TURN_IN.
- IDLE: start=1 moves to LOAD_K; counters k_cnt, x_cnt, ch, x, y are cleared.
- LOAD_K: con_ready=1. Each handshake pulses ld_k_en with ld_idx=k_cnt and increments k_cnt. The handshake at K_BEATS-1 moves to LOAD_X.
- LOAD_X: con_ready=1. Each handshake pulses ld_x_en. The handshake at X_BEATS-1 moves to TURN_OUT.
- TURN_OUT, one cycle: con_ready=0, dut_driving_cons rises. Next state is DRIVE_OUT.
- DRIVE_OUT: res_ready=1, dut_driving_cons=1.
  - res_valid registers res_data into con_out_1..3 and asserts output_valid the next cycle with the current (x, y, ch). ch then advances by 3.
  - After the beat with ch = OUTPUT_NB_CHANNELS-3, ch wraps to 0 and x increments. x wraps at FEATURE_MAP_WIDTH-1 and increments y.
  - Once the last registered beat is on the bus: if the pixel was (W-1, H-1), go to IDLE; otherwise go to TURN_IN.
- TURN_IN, one cycle: dut_driving_cons=0, con_ready=0. Next state is LOAD_X with x_cnt=0.
- Beat accounting: con_valid with con_ready=0 has no effect; the bench holds the data. Kernel beats are loaded once per layer only.

## Timing
- Reset (arst_n=0 at a clock edge): state=IDLE and every output is 0 (including con_out_*, output_x/y/ch, dut_driving_cons) from the next cycle. This applies mid-layer too; partial loads are discarded.
- start to first con_ready: running and con_ready assert in the cycle after start is sampled.
- dut_driving_cons:
  - Only toggles in TURN_OUT/TURN_IN, never in a cycle with con_ready=1.
  - It is registered, so the bus is never driven by both sides across an edge.
- Result latency: res handshake at edge n gives output_valid=1 during cycle n+1. output_valid is a single-cycle pulse per beat; there is no ready.
- Back-to-back results: one output beat per cycle is sustained in DRIVE_OUT.
- Final beat: running deasserts in the cycle after the last output_valid, and start is accepted the same cycle.
- start asserted while running: ignored, no state change.

## Structure
- Shared package (alongside config_t): state enum `con_seq_state_t`, beat-index width function, OUTPUT_NB_CHANNELS%3 check macro.
- Sub-module `coord_counter`: nested ch/x/y counters with advance/clear inputs and a last-pixel flag.

## Test plan
- Reset mid-LOAD_X (k done, x_cnt=1): all outputs 0 next cycle; a new start reloads all 18 K beats.
- Full layer with W=H=2, OUT_CH=6: exactly 18 ld_k_en, then 4×3 ld_x_en, then 8 output_valid with (x,y,ch) = (0,0,0),(0,0,3),(1,0,0),(1,0,3),…,(1,1,3); running falls after the last one.
- con_valid stalls (valid low 3 cycles mid-K): k_cnt holds; last_load_K is high only during the cycle pairing with beat 17.
- res_valid gaps: res_valid 1,0,0,1 gives output_valid exactly one cycle after each handshake, with con_out matching res_data.
- Turnaround: con_ready=0 in the TURN_OUT/TURN_IN cycles; dut_driving_cons is never 1 while con_ready=1.
- start pulsed during DRIVE_OUT: ignored; counters and outputs unchanged.
